// File: rtl/reg_bank_n_if.sv
// reg_bank_n_if: operand/control bus of the register bank, shared by the ALU side (master) and the bank (slave).
// Shadow save/restore controls and the wrap/shadow status travel on the same bundle.
interface reg_bank_n_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int SELW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    logic [DEPTH-1:0] i_reg_sel;
    logic [1:0]       i_fun_sel;
    logic [WIDTH-1:0] i_data;
    logic [SELW-1:0]  i_out_a_sel;
    logic [SELW-1:0]  i_out_b_sel;
    logic             i_save;
    logic             i_restore;
    logic [WIDTH-1:0] o_out_a;
    logic [WIDTH-1:0] o_out_b;
    logic [DEPTH-1:0] o_wrap;
    logic             o_shadow_valid;
    modport master (
        output i_reg_sel, i_fun_sel, i_data, i_out_a_sel, i_out_b_sel, i_save, i_restore,
        input  o_out_a, o_out_b, o_wrap, o_shadow_valid
    );
    modport slave (
        input  i_reg_sel, i_fun_sel, i_data, i_out_a_sel, i_out_b_sel, i_save, i_restore,
        output o_out_a, o_out_b, o_wrap, o_shadow_valid
    );
endinterface

// File: rtl/reg_bank_n.sv
// reg_bank_n: DEPTH x WIDTH register bank with clear/load/dec/inc, two async read ports, one-deep shadow bank, sticky wrap flags.
// Define REG_BANK_SATURATE_EN to make increment/decrement saturate instead of wrapping.
module reg_bank_n #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    reg_bank_n_if.slave bus
);
    localparam int SELW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    logic [WIDTH-1:0] r_live       [DEPTH];
    logic [WIDTH-1:0] r_shadow     [DEPTH];
    logic [DEPTH-1:0] r_wrap;
    logic             r_shadow_valid;
    logic [WIDTH-1:0] w_live_nxt   [DEPTH];
    logic [WIDTH-1:0] w_shadow_nxt [DEPTH];
    logic [DEPTH-1:0] w_wrap_nxt;
    logic [DEPTH-1:0] w_at_lim;
    logic             w_restore;
    logic             w_sv_nxt;
    logic [WIDTH-1:0] w_rd         [2**SELW];
    // A restore only takes effect with a saved context; it then overrides the live op.
    always_comb begin
        w_restore = bus.i_restore & r_shadow_valid;
        w_sv_nxt  = bus.i_save | (r_shadow_valid & ~w_restore);
        w_at_lim  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_shadow_nxt[k] = bus.i_save ? r_live[k] : r_shadow[k];
            w_live_nxt[k]   = r_live[k];
            w_wrap_nxt[k]   = r_wrap[k];
            w_at_lim[k]     = bus.i_fun_sel[0] ? (r_live[k] == ALL_ONES) : (r_live[k] == '0);
            if (w_restore) begin
                w_live_nxt[k] = r_shadow[k];
                w_wrap_nxt[k] = 1'b0;
            end else if (!bus.i_reg_sel[k]) begin
                if (!bus.i_fun_sel[1]) begin
                    w_live_nxt[k] = bus.i_fun_sel[0] ? bus.i_data : '0;
                    w_wrap_nxt[k] = 1'b0;
                end else begin
                    w_wrap_nxt[k] = r_wrap[k] | w_at_lim[k];
`ifdef REG_BANK_SATURATE_EN
                    w_live_nxt[k] = w_at_lim[k] ? r_live[k] :
                                    bus.i_fun_sel[0] ? r_live[k] + 1'b1 : r_live[k] - 1'b1;
`else
                    w_live_nxt[k] = bus.i_fun_sel[0] ? r_live[k] + 1'b1 : r_live[k] - 1'b1;
`endif
                end
            end
        end
    end
    // Pad the read mux to the full select range so out-of-range selects read zero.
    always_comb begin
        w_rd = '{default: '0};
        for (int j = 0; j < DEPTH; j++) w_rd[j] = r_live[j];
    end
    assign bus.o_out_a        = w_rd[bus.i_out_a_sel];
    assign bus.o_out_b        = w_rd[bus.i_out_b_sel];
    assign bus.o_wrap         = r_wrap;
    assign bus.o_shadow_valid = r_shadow_valid;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_live         <= '{default: '0};
            r_shadow       <= '{default: '0};
            r_wrap         <= '0;
            r_shadow_valid <= 1'b0;
        end else begin
            r_live         <= w_live_nxt;
            r_shadow       <= w_shadow_nxt;
            r_wrap         <= w_wrap_nxt;
            r_shadow_valid <= w_sv_nxt;
        end
    end
endmodule

// File: tb/tb_reg_bank_n.sv
// tb_reg_bank_n: directed vector table, hand-written reset/bypass sequences and randomized run against an array model.
module tb_reg_bank_n;
    localparam int W = 8;
    localparam int D = 4;
    localparam int MAXV = 255;
`ifdef REG_BANK_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam logic [7:0] INC_FF = SAT ? 8'hFF : 8'h00;
    localparam logic [7:0] DEC_00 = SAT ? 8'h00 : 8'hFF;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    reg_bank_n_if #(.WIDTH(W), .DEPTH(D)) bus ();
    reg_bank_n #(.WIDTH(W), .DEPTH(D)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
    int errors = 0;
    int checks = 0;
    typedef struct {
        logic [3:0] rs; logic [1:0] fs; logic [7:0] d; logic sv; logic rt;
        logic [1:0] sa; logic [1:0] sb; logic [7:0] ea; logic [7:0] eb; logic [3:0] ew; logic esv;
    } vec_t;
    vec_t tbl [16];
    int m_live [D];
    int m_sh [D];
    bit m_wrap [D];
    bit m_sv;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic drive(input logic [3:0] rs, input logic [1:0] fs, input logic [7:0] d,
                         input logic sv, input logic rt, input logic [1:0] sa, input logic [1:0] sb);
        bus.i_reg_sel = rs; bus.i_fun_sel = fs; bus.i_data = d;
        bus.i_save = sv; bus.i_restore = rt; bus.i_out_a_sel = sa; bus.i_out_b_sel = sb;
    endtask
    function automatic void model_reset();
        for (int k = 0; k < D; k++) begin m_live[k] = 0; m_sh[k] = 0; m_wrap[k] = 0; end
        m_sv = 0;
    endfunction
    function automatic void model_edge(input logic [3:0] rs, input logic [1:0] fs, input int d,
                                       input bit sv, input bit rt);
        int old [D];
        bit rest;
        old = m_live;
        rest = rt && m_sv;
        for (int k = 0; k < D; k++) begin
            if (rest) begin
                m_live[k] = m_sh[k]; m_wrap[k] = 0;
            end else if (!rs[k]) begin
                case (fs)
                    2'd0: begin m_live[k] = 0; m_wrap[k] = 0; end
                    2'd1: begin m_live[k] = d; m_wrap[k] = 0; end
                    2'd2: if (m_live[k] == 0) begin m_wrap[k] = 1; m_live[k] = SAT ? 0 : MAXV; end
                          else m_live[k] = m_live[k] - 1;
                    default: if (m_live[k] == MAXV) begin m_wrap[k] = 1; m_live[k] = SAT ? MAXV : 0; end
                             else m_live[k] = m_live[k] + 1;
                endcase
            end
        end
        if (sv) m_sh = old;
        m_sv = sv ? 1'b1 : (rest ? 1'b0 : m_sv);
    endfunction
    function automatic logic [3:0] m_wrap_vec();
        logic [3:0] v;
        for (int k = 0; k < D; k++) v[k] = m_wrap[k];
        return v;
    endfunction
    task automatic chk_model(input string tag);
        chk({tag, "_a"}, {24'd0, bus.o_out_a}, m_live[bus.i_out_a_sel]);
        chk({tag, "_b"}, {24'd0, bus.o_out_b}, m_live[bus.i_out_b_sel]);
        chk({tag, "_wrap"}, {28'd0, bus.o_wrap}, {28'd0, m_wrap_vec()});
        chk({tag, "_sv"}, {31'd0, bus.o_shadow_valid}, {31'd0, m_sv});
    endtask
    initial begin
        tbl[0]  = '{4'b1110, 2'd1, 8'hA5, 0, 0, 2'd0, 2'd1, 8'hA5, 8'h00, 4'h0, 0};
        tbl[1]  = '{4'b1011, 2'd1, 8'hFF, 0, 0, 2'd2, 2'd0, 8'hFF, 8'hA5, 4'h0, 0};
        tbl[2]  = '{4'b1011, 2'd3, 8'h00, 0, 0, 2'd2, 2'd0, INC_FF, 8'hA5, 4'b0100, 0};
        tbl[3]  = '{4'b1011, 2'd1, 8'h10, 0, 0, 2'd2, 2'd0, 8'h10, 8'hA5, 4'h0, 0};
        tbl[4]  = '{4'b1110, 2'd1, 8'h11, 0, 0, 2'd0, 2'd2, 8'h11, 8'h10, 4'h0, 0};
        tbl[5]  = '{4'b1110, 2'd3, 8'h00, 1, 0, 2'd0, 2'd2, 8'h12, 8'h10, 4'h0, 1};
        tbl[6]  = '{4'b1110, 2'd0, 8'h00, 0, 1, 2'd0, 2'd2, 8'h11, 8'h10, 4'h0, 0};
        tbl[7]  = '{4'b1101, 2'd1, 8'h33, 0, 0, 2'd1, 2'd0, 8'h33, 8'h11, 4'h0, 0};
        tbl[8]  = '{4'b1111, 2'd0, 8'h00, 1, 0, 2'd1, 2'd0, 8'h33, 8'h11, 4'h0, 1};
        tbl[9]  = '{4'b1101, 2'd1, 8'h22, 0, 0, 2'd1, 2'd0, 8'h22, 8'h11, 4'h0, 1};
        tbl[10] = '{4'b1101, 2'd0, 8'h00, 1, 1, 2'd1, 2'd0, 8'h33, 8'h11, 4'h0, 1};
        tbl[11] = '{4'b1111, 2'd0, 8'h00, 0, 1, 2'd1, 2'd0, 8'h22, 8'h11, 4'h0, 0};
        tbl[12] = '{4'b0111, 2'd1, 8'h05, 0, 0, 2'd3, 2'd1, 8'h05, 8'h22, 4'h0, 0};
        tbl[13] = '{4'b0111, 2'd3, 8'h00, 0, 1, 2'd3, 2'd1, 8'h06, 8'h22, 4'h0, 0};
        tbl[14] = '{4'b1101, 2'd0, 8'h00, 0, 0, 2'd1, 2'd3, 8'h00, 8'h06, 4'h0, 0};
        tbl[15] = '{4'b1101, 2'd2, 8'h00, 0, 0, 2'd1, 2'd3, DEC_00, 8'h06, 4'b0010, 0};
        drive(4'b1111, 2'd0, 8'h00, 0, 0, 2'd0, 2'd1);
        #12;
        chk("rst_a", {24'd0, bus.o_out_a}, 0);
        chk("rst_b", {24'd0, bus.o_out_b}, 0);
        chk("rst_wrap", {28'd0, bus.o_wrap}, 0);
        chk("rst_sv", {31'd0, bus.o_shadow_valid}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].rs, tbl[i].fs, tbl[i].d, tbl[i].sv, tbl[i].rt, tbl[i].sa, tbl[i].sb);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_a", i), {24'd0, bus.o_out_a}, {24'd0, tbl[i].ea});
            chk($sformatf("vec%0d_b", i), {24'd0, bus.o_out_b}, {24'd0, tbl[i].eb});
            chk($sformatf("vec%0d_wrap", i), {28'd0, bus.o_wrap}, {28'd0, tbl[i].ew});
            chk($sformatf("vec%0d_sv", i), {31'd0, bus.o_shadow_valid}, {31'd0, tbl[i].esv});
        end
        // Async reset landing between edges while a swap is pending.
        drive(4'b1110, 2'd1, 8'h11, 1, 0, 2'd0, 2'd3);
        @(posedge clk); #1;
        drive(4'b1111, 2'd0, 8'h00, 1, 1, 2'd0, 2'd3);
        chk("pre_rst_a", {24'd0, bus.o_out_a}, 32'h11);
        chk("pre_rst_sv", {31'd0, bus.o_shadow_valid}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_a", {24'd0, bus.o_out_a}, 0);
        chk("midrst_b", {24'd0, bus.o_out_b}, 0);
        chk("midrst_wrap", {28'd0, bus.o_wrap}, 0);
        chk("midrst_sv", {31'd0, bus.o_shadow_valid}, 0);
        #2 rst_n = 1'b1;
        drive(4'b1110, 2'd1, 8'h44, 0, 1, 2'd0, 2'd1);
        @(posedge clk); #1;
        chk("postrst_a", {24'd0, bus.o_out_a}, 32'h44);
        chk("postrst_b", {24'd0, bus.o_out_b}, 0);
        chk("postrst_sv", {31'd0, bus.o_shadow_valid}, 0);
        // Read of the register being written returns the old value until the edge.
        drive(4'b1110, 2'd1, 8'h77, 0, 0, 2'd0, 2'd0);
        #1 chk("nobypass_a", {24'd0, bus.o_out_a}, 32'h44);
        @(posedge clk); #1;
        chk("written_a", {24'd0, bus.o_out_a}, 32'h77);
        // Randomized run from a fresh reset against the model.
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        model_reset();
        for (int n = 0; n < 600; n++) begin
            logic [3:0] rs; logic [1:0] fs; logic [7:0] d; logic sv, rt;
            rs = 4'($urandom); fs = 2'($urandom); d = 8'($urandom);
            d = ($urandom_range(0, 7) == 0) ? 8'hFF : ($urandom_range(0, 7) == 0) ? 8'h00 : d;
            sv = ($urandom_range(0, 3) == 0); rt = ($urandom_range(0, 3) == 0);
            drive(rs, fs, d, sv, rt, 2'($urandom), 2'($urandom));
            #1 chk_model("rnd_pre");
            @(posedge clk);
            model_edge(rs, fs, int'(d), sv, rt);
            #1 chk_model("rnd");
            if ($urandom_range(0, 49) == 0) begin
                rst_n = 1'b0;
                #1 model_reset();
                chk_model("rnd_rst");
                rst_n = 1'b1;
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reg_bank_n.md
# reg_bank_n

Parametrised successor to the fixed 4×8 register file: a bank of DEPTH general-purpose registers, each WIDTH bits, with the established clear/load/decrement/increment function set and two asynchronous read ports. Adds a one-deep shadow bank for single-cycle context save, restore and swap, plus per-register sticky wrap flags. Sits in the datapath between the ALU result bus and the ALU operand muxes, replacing the fixed-size RegFile in wider configurations.

## Interface
Parameters:
- WIDTH, 8, register width in bits (≥2)
- DEPTH, 4, number of registers (2..16)
- SELW, derived ceil(log2(DEPTH)), read-select width; localparam, not overridable

Ports:
- CLK  in  1  clock; all state changes on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- RegSel  in  DEPTH  per-register enable, active-low; bit k=0 enables register k
- FunSel  in  2  0 clear, 1 load I, 2 decrement, 3 increment
- I  in  WIDTH  load data
- OutASel  in  SELW  read select, port A
- OutBSel  in  SELW  read select, port B
- Save  in  1  copy live bank into shadow bank
- Restore  in  1  copy shadow bank into live bank
- OutA  out  WIDTH  live register[OutASel]
- OutB  out  WIDTH  live register[OutBSel]
- Wrap  out  DEPTH  sticky per-register wrap flag
- ShadowValid  out  1  shadow bank holds a saved context

## Operation
- Live op, per register k with RegSel[k]=0: FunSel applied; registers with RegSel[k]=1 hold.
- Increment of all-ones gives 0; decrement of 0 gives all-ones; arithmetic modulo 2^WIDTH. Either case sets Wrap[k].
- Wrap[k] clears when register k takes FunSel 0 or 1. Otherwise it holds.
- OutA/OutB are combinational from stored values and select inputs. They follow any change of select or register contents in the same cycle, with no stale-latch behaviour. A select ≥ DEPTH reads 0.
- Save only: shadow ← live values as they stood before this edge. ShadowValid ← 1. The live op still executes in the same cycle.
- Restore only, ShadowValid=1: live ← shadow. The live op is suppressed for that cycle. All Wrap flags clear. ShadowValid ← 0.
- Restore only, ShadowValid=0: Restore is ignored and the live op executes normally.
- Save and Restore together, ShadowValid=1: the banks swap (live ← shadow, shadow ← old live). The live op is suppressed. Wrap clears. ShadowValid stays 1.
- Save and Restore together, ShadowValid=0: treated as Save only.

## Timing
- Reset (RST_N=0, asynchronous, no clock needed): all live and shadow registers 0, Wrap=0, ShadowValid=0, so OutA=OutB=0. Reset held overrides every other input.
- Reset deasserted mid-operation: the first rising edge after release performs a normal op. No pending Save or Restore survives reset.
- Write latency 1 cycle: a value written at edge n is visible on OutA/OutB after edge n, in cycle n+1.
- There is no read-during-write bypass by default. A read of the register being written returns the old value until the edge.
- Save, Restore and swap each complete in exactly 1 cycle. Back-to-back operations on consecutive edges are legal.

## Configuration
- REG_BANK_SATURATE_EN defined: increment saturates at all-ones and decrement saturates at 0. Wrap[k] sets on any saturating attempt, and the register value is unchanged.
- REG_BANK_SATURATE_EN undefined: modulo wrap as described in Operation.
- Clear, load, shadow and flag behaviour are identical in both builds.

## Test plan
- Reset then load: RST_N pulse low; RegSel=4'b1110, FunSel=1, I=8'hA5, one edge; OutASel=0 → OutA=8'hA5. OutBSel=1 → OutB=8'h00, Wrap=0.
- Wrap: load R2=8'hFF, then FunSel=3 with RegSel=4'b1011 → R2=8'h00, Wrap[2]=1. Then FunSel=1, I=8'h10 → Wrap[2]=0. In the saturate build, R2 stays 8'hFF and Wrap[2]=1.
- Save/restore: R0=8'h11; Save with FunSel=3 on R0 → shadow R0=8'h11, live R0=8'h12, ShadowValid=1. Restore with FunSel=0 on R0 → R0=8'h11 (clear suppressed), ShadowValid=0.
- Swap: live R1=8'h22, shadow R1=8'h33, ShadowValid=1; assert Save and Restore → live R1=8'h33, shadow R1=8'h22, ShadowValid=1.
- Restore without saved context: ShadowValid=0; Restore with FunSel=3 on R3=8'h05 → R3=8'h06, ShadowValid=0.
- Async reset mid-swap: assert RST_N low between edges with Save=Restore=1 → all outputs 0 immediately. After release, Restore alone → no change to the live bank.
